// File: rtl/delay_timer_pkg.sv
// delay_timer_pkg: shared types and constants for the multi-channel delay timer.
//   timer_state_t  per-channel FSM state (IDLE, RUN, HOLD)
//   MODE_ONESHOT   channel returns to IDLE after one expiry
//   MODE_PERIODIC  channel reloads and keeps running after each expiry
//   presc_width()  prescaler register width for a given PRESCALE (minimum 1 bit)
package delay_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } timer_state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // A prescale of 1 still needs a 1-bit register so the port/compare widths stay legal.
  function automatic int unsigned presc_width(input int unsigned prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one countdown timer with prescaler, reload register and mode.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           load 'load' into count/reload, capture 'periodic', enter RUN
//   cancel          abort to IDLE with count cleared and no pass
//   hold            level; freezes count and prescaler while running
//   periodic        mode sampled with start (0 one-shot, 1 periodic)
//   load            load value L
//   busy            registered, 1 while in RUN or HOLD
//   pass            registered single-cycle expiry pulse
//   count           remaining ticks
module timer_channel #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cancel,
  input  logic             hold,
  input  logic             periodic,
  input  logic [WIDTH-1:0] load,
  output logic             busy,
  output logic             pass,
  output logic [WIDTH-1:0] count
);
  import delay_timer_pkg::*;

  localparam int unsigned PW = presc_width(PRESCALE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  timer_state_t   state;
  logic [PW-1:0]  presc;
  logic [WIDTH-1:0] reload;
  logic           mode;
  logic           presc_wrap_c;

  // Prescaler has reached its last step; the next advancing cycle is a tick.
  assign presc_wrap_c = (presc == PRESC_LAST);

  // Channel FSM, prescaler and counters. Priority: cancel > start > hold.
  // Leaving HOLD is itself an advancing cycle, so a hold of H cycles delays
  // expiry by exactly H cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      pass   <= 1'b0;
      count  <= '0;
      reload <= '0;
      mode   <= MODE_ONESHOT;
      presc  <= '0;
    end else begin
      pass <= 1'b0;
      if (cancel) begin
        state <= IDLE;
        busy  <= 1'b0;
        count <= '0;
        presc <= '0;
      end else if (start) begin
        // Retrigger discards the old count; any tick due this cycle is dropped.
        reload <= load;
        count  <= load;
        mode   <= periodic;
        presc  <= '0;
        state  <= RUN;
        busy   <= 1'b1;
      end else if (state != IDLE) begin
        if (hold) begin
          state <= HOLD;
        end else begin
          state <= RUN;
          if (presc_wrap_c) begin
            presc <= '0;
            if (count != '0) begin
              count <= count - WIDTH'(1);
            end else begin
              pass <= 1'b1;
              if (mode == MODE_PERIODIC) begin
                count <= reload;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/delay_timer.sv
// delay_timer: CHANNELS independent programmable delay timers.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start[i]        load and (re)start channel i
//   cancel[i]       abort channel i without pass
//   hold[i]         freeze channel i while high
//   periodic[i]     mode for channel i, sampled with start
//   load            load values, channel i at [i*WIDTH +: WIDTH]
//   busy[i]         channel i in RUN or HOLD
//   pass[i]         one-cycle expiry pulse of channel i
//   count           remaining ticks, same packing as load
module delay_timer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       cancel,
  input  logic [CHANNELS-1:0]       hold,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic [CHANNELS*WIDTH-1:0] load,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       pass,
  output logic [CHANNELS*WIDTH-1:0] count
);
  import delay_timer_pkg::*;

  // One timer per channel; the top only slices the packed buses.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    timer_channel #(
      .WIDTH    (WIDTH),
      .PRESCALE (PRESCALE)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .start    (start[i]),
      .cancel   (cancel[i]),
      .hold     (hold[i]),
      .periodic (periodic[i]),
      .load     (load[i*WIDTH +: WIDTH]),
      .busy     (busy[i]),
      .pass     (pass[i]),
      .count    (count[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_delay_timer.sv
// tb_delay_timer: directed scenarios plus randomized traffic against an
// elapsed-cycle reference model, on a PRESCALE=1 and a PRESCALE=4 instance
// sharing the same inputs.
module tb_delay_timer;
  localparam int unsigned W = 8;
  localparam int unsigned C = 2;

  logic clk;
  logic rst;
  logic [C-1:0]   start, cancel, hold, periodic;
  logic [C*W-1:0] load;
  logic [C-1:0]   busy1, pass1, busy4, pass4;
  logic [C*W-1:0] count1, count4;

  int tests = 0;
  int fails = 0;

  // Reference model: per instance d and channel c, the delay is "active" and
  // has consumed m_el non-held cycles; expiry after (L+1)*P such cycles.
  bit m_act [2][C];
  bit m_per [2][C];
  int m_len [2][C];
  int m_el  [2][C];
  bit m_pass[2][C];
  int presc_of[2] = '{1, 4};

  delay_timer #(.WIDTH(W), .CHANNELS(C), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .cancel(cancel), .hold(hold),
    .periodic(periodic), .load(load), .busy(busy1), .pass(pass1), .count(count1)
  );

  delay_timer #(.WIDTH(W), .CHANNELS(C), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .cancel(cancel), .hold(hold),
    .periodic(periodic), .load(load), .busy(busy4), .pass(pass4), .count(count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < C; c++) begin
        m_act[d][c] = 0; m_per[d][c] = 0; m_len[d][c] = 0;
        m_el[d][c] = 0;  m_pass[d][c] = 0;
      end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < C; c++) begin
        m_pass[d][c] = 0;
        if (rst) begin
          m_act[d][c] = 0; m_el[d][c] = 0; m_len[d][c] = 0; m_per[d][c] = 0;
        end else if (cancel[c]) begin
          m_act[d][c] = 0; m_el[d][c] = 0;
        end else if (start[c]) begin
          m_act[d][c] = 1; m_el[d][c] = 0;
          m_len[d][c] = int'(load[c*W +: W]);
          m_per[d][c] = periodic[c];
        end else if (m_act[d][c] && !hold[c]) begin
          m_el[d][c]++;
          if (m_el[d][c] == (m_len[d][c] + 1) * presc_of[d]) begin
            m_pass[d][c] = 1;
            m_el[d][c] = 0;
            if (!m_per[d][c]) m_act[d][c] = 0;
          end
        end
      end
  endtask

  function automatic logic [W-1:0] exp_count(input int d, input int c);
    if (!m_act[d][c]) return '0;
    return W'(m_len[d][c] - m_el[d][c] / presc_of[d]);
  endfunction

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic clk_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic launch(input int c, input int l, input bit per);
    start[c] = 1'b1;
    load[c*W +: W] = W'(l);
    periodic[c] = per;
  endtask

  task automatic quiesce();
    start = '0; hold = '0; periodic = '0; load = '0; cancel = '1;
    clk_edge();
    cancel = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = '0; cancel = '0; hold = '0; periodic = '0; load = '0;
    model_reset();
    repeat (3) clk_edge();
    tests++;
    if ({busy1, pass1, count1} !== '0) begin
      fails++; $display("FAIL reset_p1: got %0h expected 0", {busy1, pass1, count1});
    end
    tests++;
    if ({busy4, pass4, count4} !== '0) begin
      fails++; $display("FAIL reset_p4: got %0h expected 0", {busy4, pass4, count4});
    end
    rst = 1'b0;
    clk_edge();
    tests++;
    if ({busy1, pass1, count1, busy4, pass4, count4} !== '0) begin
      fails++; $display("FAIL reset_release: outputs not idle after release");
    end
  endtask

  task automatic test_oneshot();
    quiesce();
    launch(0, 7, 0);
    clk_edge();
    start = '0;
    tests++;
    if (busy1 !== 2'b01 || count1[7:0] !== 8'd7) begin
      fails++; $display("FAIL oneshot_start: busy=%b count=%0d expected busy=01 count=7", busy1, count1[7:0]);
    end
    for (int n = 1; n <= 9; n++) begin
      clk_edge();
      tests++;
      if (pass1[0] !== (n == 8) || busy1[0] !== (n < 8) || busy1[1] !== 1'b0 || pass1[1] !== 1'b0
          || count1[7:0] !== ((n < 8) ? 8'(7 - n) : 8'd0)) begin
        fails++;
        $display("FAIL oneshot_edge%0d: pass=%b busy=%b count=%0d expected pass0=%0d busy0=%0d ch1 idle",
                 n, pass1, busy1, count1[7:0], (n == 8), (n < 8));
      end
    end
  endtask

  task automatic test_periodic_prescale();
    quiesce();
    launch(0, 2, 1);
    clk_edge();
    start = '0; periodic = '0;
    for (int n = 1; n <= 36; n++) begin
      clk_edge();
      tests++;
      if (pass4[0] !== (n % 12 == 0) || busy4[0] !== 1'b1 || count4[7:0] !== 8'(2 - (n % 12) / 4)) begin
        fails++;
        $display("FAIL periodic_edge%0d: pass=%b busy=%b count=%0d expected pass=%0d count=%0d",
                 n, pass4[0], busy4[0], count4[7:0], (n % 12 == 0), 2 - (n % 12) / 4);
      end
    end
    cancel[0] = 1'b1;
    clk_edge();
    cancel = '0;
    for (int n = 1; n <= 24; n++) begin
      clk_edge();
      tests++;
      if (pass4[0] !== 1'b0 || busy4[0] !== 1'b0 || count4[7:0] !== 8'd0) begin
        fails++;
        $display("FAIL periodic_cancel%0d: pass=%b busy=%b count=%0d expected all 0",
                 n, pass4[0], busy4[0], count4[7:0]);
      end
    end
  endtask

  task automatic test_hold();
    quiesce();
    launch(0, 5, 0);
    clk_edge();
    start = '0;
    for (int n = 1; n <= 11; n++) begin
      hold[0] = (n >= 2 && n <= 4);
      clk_edge();
      tests++;
      if (pass1[0] !== (n == 9) || busy1[0] !== (n < 9)) begin
        fails++; $display("FAIL hold_edge%0d: pass=%b busy=%b expected pass=%0d busy=%0d",
                          n, pass1[0], busy1[0], (n == 9), (n < 9));
      end
      if (n >= 2 && n <= 4) begin
        tests++;
        if (count1[7:0] !== 8'd4) begin
          fails++; $display("FAIL hold_freeze%0d: count=%0d expected 4", n, count1[7:0]);
        end
      end
    end
    hold = '0;
  endtask

  task automatic test_retrigger_priority();
    quiesce();
    launch(0, 5, 0);
    clk_edge();
    start = '0;
    for (int n = 1; n <= 9; n++) begin
      if (n == 3) launch(0, 2, 0);
      clk_edge();
      start = '0;
      tests++;
      if (pass1[0] !== (n == 6)) begin
        fails++; $display("FAIL retrigger_edge%0d: pass=%b expected %0d", n, pass1[0], (n == 6));
      end
    end
    // start together with cancel: cancel wins
    quiesce();
    launch(0, 3, 0);
    clk_edge();
    start = '0;
    clk_edge();
    launch(0, 0, 0);
    cancel[0] = 1'b1;
    clk_edge();
    start = '0; cancel = '0;
    tests++;
    if (busy1[0] !== 1'b0 || count1[7:0] !== 8'd0 || pass1[0] !== 1'b0) begin
      fails++; $display("FAIL priority: busy=%b count=%0d pass=%b expected 0 0 0", busy1[0], count1[7:0], pass1[0]);
    end
    for (int n = 0; n < 6; n++) begin
      clk_edge();
      tests++;
      if (pass1[0] !== 1'b0 || busy1[0] !== 1'b0) begin
        fails++; $display("FAIL priority_after%0d: pass=%b busy=%b expected 0", n, pass1[0], busy1[0]);
      end
    end
    // cancel on the very cycle expiry is due
    quiesce();
    launch(0, 1, 0);
    clk_edge();
    start = '0;
    clk_edge();
    cancel[0] = 1'b1;
    clk_edge();
    cancel = '0;
    tests++;
    if (pass1[0] !== 1'b0 || busy1[0] !== 1'b0) begin
      fails++; $display("FAIL cancel_at_expiry: pass=%b busy=%b expected 0 0", pass1[0], busy1[0]);
    end
    clk_edge();
    tests++;
    if (pass1[0] !== 1'b0) begin
      fails++; $display("FAIL cancel_at_expiry_late: pass=%b expected 0", pass1[0]);
    end
  endtask

  task automatic test_boundaries();
    quiesce();
    launch(0, 0, 0);
    clk_edge();
    start = '0;
    tests++;
    if (busy1[0] !== 1'b1 || count1[7:0] !== 8'd0) begin
      fails++; $display("FAIL l0_start: busy=%b count=%0d expected 1 0", busy1[0], count1[7:0]);
    end
    for (int n = 1; n <= 3; n++) begin
      clk_edge();
      tests++;
      if (pass1[0] !== (n == 1)) begin
        fails++; $display("FAIL l0_edge%0d: pass=%b expected %0d", n, pass1[0], (n == 1));
      end
    end
    quiesce();
    launch(0, 255, 0);
    clk_edge();
    start = '0;
    for (int n = 1; n <= 258; n++) begin
      clk_edge();
      tests++;
      if (pass1[0] !== (n == 256) || busy1[0] !== (n < 256)) begin
        fails++; $display("FAIL l255_edge%0d: pass=%b busy=%b expected pass=%0d busy=%0d",
                          n, pass1[0], busy1[0], (n == 256), (n < 256));
      end
    end
    // asynchronous reset in the middle of a count
    quiesce();
    launch(0, 10, 0);
    launch(1, 3, 1);
    clk_edge();
    start = '0; periodic = '0;
    repeat (3) clk_edge();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    tests++;
    if ({busy1, pass1, count1, busy4, pass4, count4} !== '0) begin
      fails++; $display("FAIL async_reset: busy1=%b count1=%0h busy4=%b count4=%0h expected 0",
                        busy1, count1, busy4, count4);
    end
    clk_edge();
    rst = 1'b0;
    for (int n = 0; n < 15; n++) begin
      clk_edge();
      tests++;
      if ({pass1, pass4, busy1, busy4} !== '0) begin
        fails++; $display("FAIL reset_no_pass%0d: pass1=%b pass4=%b busy1=%b busy4=%b expected 0",
                          n, pass1, pass4, busy1, busy4);
      end
    end
  endtask

  task automatic test_independence();
    quiesce();
    launch(0, 3, 0);
    launch(1, 6, 0);
    clk_edge();
    start = '0;
    for (int n = 1; n <= 8; n++) begin
      clk_edge();
      tests++;
      if (pass1 !== {(n == 7), (n == 4)}) begin
        fails++; $display("FAIL indep_edge%0d: pass=%b expected %b%b", n, pass1, (n == 7), (n == 4));
      end
    end
    quiesce();
    launch(0, 3, 0);
    launch(1, 6, 0);
    clk_edge();
    start = '0;
    for (int n = 1; n <= 8; n++) begin
      cancel[0] = (n == 2);
      clk_edge();
      tests++;
      if (pass1[1] !== (n == 7) || pass1[0] !== 1'b0 || busy1[0] !== (n < 2) || busy1[1] !== (n < 7)) begin
        fails++; $display("FAIL indep_cancel%0d: pass=%b busy=%b expected pass=%0d0 busy=%0d%0d",
                          n, pass1, busy1, (n == 7), (n < 7), (n < 2));
      end
    end
    cancel = '0;
  endtask

  task automatic test_random();
    logic [C-1:0]   eb, ep;
    logic [C*W-1:0] ec;
    quiesce();
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < C; c++) begin
        cancel[c]   = ($urandom_range(0, 31) == 0);
        start[c]    = ($urandom_range(0, 11) == 0);
        hold[c]     = ($urandom_range(0, 3) == 0);
        periodic[c] = 1'($urandom_range(0, 1));
        load[c*W +: W] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      end
      clk_edge();
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < C; c++) begin
          eb[c] = m_act[d][c];
          ep[c] = m_pass[d][c];
          ec[c*W +: W] = exp_count(d, c);
        end
        tests++;
        if (d == 0) begin
          if (busy1 !== eb || pass1 !== ep || count1 !== ec) begin
            fails++; $display("FAIL random_p1 cycle %0d: busy=%b pass=%b count=%h expected busy=%b pass=%b count=%h",
                              i, busy1, pass1, count1, eb, ep, ec);
          end
        end else begin
          if (busy4 !== eb || pass4 !== ep || count4 !== ec) begin
            fails++; $display("FAIL random_p4 cycle %0d: busy=%b pass=%b count=%h expected busy=%b pass=%b count=%h",
                              i, busy4, pass4, count4, eb, ep, ec);
          end
        end
      end
    end
    start = '0; cancel = '0; hold = '0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic_prescale();
    test_hold();
    test_retrigger_priority();
    test_boundaries();
    test_independence();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/delay_timer.md
# delay_timer

Multi-channel programmable delay timer; generalises the fixed 3-bit pass-pulse delay into `CHANNELS` independent countdown timers with run-time load value, per-channel prescaler, one-shot or periodic mode, hold, cancel and retrigger. It sits beside the elevator controller FSM and provides door-open, floor-travel and idle-timeout delays. Each timer channel signals expiry with a single-cycle `pass` pulse.

## Interface
- `WIDTH`, 8: width of load value and remaining count per channel.
- `CHANNELS`, 2: number of independent timer channels, ≥1.
- `PRESCALE`, 1: clock cycles per tick, ≥1. 1 means one tick per clock.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  CHANNELS  per channel, 1 = load and (re)start.
- `cancel`  in  CHANNELS  per channel, 1 = abort to idle without `pass`.
- `hold`  in  CHANNELS  per channel, level; 1 = freeze count and prescaler.
- `periodic`  in  CHANNELS  per channel mode, sampled with `start`: 0 = one-shot, 1 = periodic.
- `load`  in  CHANNELS*WIDTH  load value L, channel i at bits [i*WIDTH +: WIDTH].
- `busy`  out  CHANNELS  1 while channel is in RUN or HOLD.
- `pass`  out  CHANNELS  registered one-cycle expiry pulse.
- `count`  out  CHANNELS*WIDTH  remaining ticks, same packing as `load`.

## Operation
- Per-channel FSM states: IDLE, RUN, HOLD. All channels are identical and fully independent.
- Input priority per channel, evaluated each cycle: `cancel` > `start` > `hold`.
- `cancel`=1 in any state:
  - Next state is IDLE, with `count`=0 and prescaler=0.
  - `pass` stays 0, including when expiry would occur in the same cycle.
- `start`=1 without `cancel`, in any state:
  - Captures L into the reload register and `count`.
  - Captures `periodic` into the mode register.
  - Clears the prescaler and enters RUN.
  - A start in RUN or HOLD is a retrigger. It discards the old count, and a tick due that cycle is suppressed.
- Tick: state = RUN, `hold`=0 and prescaler = PRESCALE-1. Otherwise, in RUN with `hold`=0, the prescaler increments. The prescaler wraps to 0 on a tick.
- On a tick:
  - If `count` ≠ 0: `count` decrements.
  - If `count` = 0: `pass` pulses for one cycle.
  - In one-shot mode, the channel then goes to IDLE.
  - In periodic mode, the reload value is copied into `count` and the channel stays in RUN.
- RUN with `hold`=1 → HOLD. HOLD with `hold`=0 → RUN. In HOLD, `count` and the prescaler are frozen.
- L=0 is legal: expiry occurs on the first tick.
- `start` and `hold` asserted together: the channel enters RUN. `hold` takes effect from the next cycle, so no tick is possible in that cycle.
- Reset values: state IDLE, `busy`=0, `pass`=0, `count`=0, reload=0, mode=one-shot, prescaler=0.
- Reset asserted mid-operation: reset values apply immediately. No `pass` is emitted for the aborted delay.
- Arithmetic:
  - Unsigned. The prescaler is `$clog2(PRESCALE)` bits, with a minimum of 1.
  - `count` never underflows: 0 is reloaded or idled, never decremented.

## Timing
- For `start` sampled at edge k, with load L and `hold`=0 throughout:
  - `pass` is high during the cycle after edge k + (L+1)*PRESCALE.
  - `busy` is high from edge k.
- One-shot: `busy` falls on the same edge that `pass` rises.
- Periodic: `pass` repeats every (L+1)*PRESCALE cycles until `cancel` or a new `start`.
- A hold of H cycles in RUN extends expiry by exactly H cycles.
- `count` is updated on the edge after the tick, with a latency of 0 from the internal register.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `delay_timer_pkg` holds:
  - state enum `timer_state_t` (IDLE, RUN, HOLD);
  - mode constants `MODE_ONESHOT`=0 and `MODE_PERIODIC`=1.
- Sub-module `timer_channel`: one FSM, prescaler, count and reload registers, with parameters WIDTH and PRESCALE.
- `delay_timer` instantiates `timer_channel` CHANNELS times in a generate loop and only packs and unpacks the buses.

## Test plan
- One-shot: PRESCALE=1, ch0 L=7, `start` pulse at edge 0.
  - Expect `pass[0]` high in the cycle after edge 8, exactly one cycle wide.
  - Expect `busy[0]` low from edge 8; ch1 stays idle.
- Periodic with prescale: PRESCALE=4, L=2, `periodic`=1. Expect `pass` every 12 cycles, 3 pulses, then `cancel`. Expect no further `pass`, `count`=0, `busy`=0.
- Hold: PRESCALE=1, L=5. Hold for 3 cycles at edge 2. Expect `count` frozen at 4 during the hold and `pass` after edge 9 instead of edge 6.
- Retrigger and priority:
  - Retrigger: L=5, restart with L=2 at edge 3. Expect `pass` after edge 6.
  - Priority: `start` and `cancel` in the same cycle. Expect IDLE with no `pass`.
- Boundaries:
  - L=0 with PRESCALE=1: `pass` after edge 1.
  - L=255 with WIDTH=8: `pass` after edge 256.
  - `rst` asserted mid-count: outputs clear asynchronously and no `pass` occurs.
- Independence: both channels started the same cycle with L=3 and L=6. Expect pulses after edges 4 and 7, and cancelling ch0 does not affect ch1.
